bcd_binary_seq: RTL and testbench
=================================

Name: bcd_binary_seq

Overview:
Sequential BCD-to-binary converter, the inverse of the combinational binary-to-BCD block.
- Accepts a packed multi-digit BCD word over a valid/ready handshake.
- Converts it digit-serially, most-significant digit first, using multiply-by-10 accumulate.
- Presents the binary result with its own valid/ready handshake. Sits between BCD keypad/display logic and binary arithmetic datapaths.

Parameters:
DIGITS, 4, number of BCD digits in the input word (>=1)
BIN_W, 14, binary result width; must be >= ceil(log2(10^DIGITS)), which is 14 for DIGITS=4

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  bcd holds a word to convert
in_ready  output  1  block can accept a word
bcd  input  4*DIGITS  packed BCD, digit DIGITS-1 in MSBs
out_valid  output  1  bin/err hold a completed result
out_ready  input  1  consumer takes result
bin  output  BIN_W  binary result
err  output  1  some input digit was >9 (see Optional Feature)

Behaviour:
Interface:
- One clock. Reset is asynchronous, active-low (rst_n); all state is clocked on the rising edge of clk.

Reset:
- Reset values: state=IDLE, in_ready=1, out_valid=0, bin=0, err=0, internal accumulator=0, digit counter=0.
- Reset asserted at any time, including mid-conversion or while out_valid=1, aborts immediately. No partial result is ever presented.

States:
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready at an edge: latch bcd into the shift register, clear acc, cnt and the error flag; go to CONV.
- CONV:
  - in_ready=0.
  - Each cycle: acc <= acc*10 + top digit, computed as (acc<<3)+(acc<<1)+digit, truncated to BIN_W bits. Then shift the register left 4 and increment cnt.
  - After exactly DIGITS CONV cycles: load bin<=final acc, go to DONE.
- DONE:
  - out_valid=1; bin and err stable.
  - On out_ready=1: go to IDLE. in_ready stays 0 during DONE, so no same-cycle accept.
  - out_ready held low: bin, err and out_valid are held indefinitely.

Latency and timing:
- Input accepted at edge N; out_valid rises after edge N+DIGITS.
- Minimum initiation interval is DIGITS+2 cycles.
- bcd and in_valid are ignored outside IDLE.
- out_valid never drops without out_ready.

Arithmetic and width:
- Arithmetic is unsigned, modulo 2^BIN_W.
- If BIN_W is undersized, the result wraps silently; it is the integrator's duty to size BIN_W correctly.

Boundary cases:
- bcd=0: bin=0 after DIGITS cycles.
- DIGITS=1: one CONV cycle.

Optional Feature:
Macro BCD_DIGIT_CHECK_EN.
- Defined:
  - Every digit is compared with 9 as it is consumed in CONV.
  - A sticky flag sets if any digit is >9; err<=flag on entry to DONE.
  - The conversion still completes arithmetically, so bin is the raw accumulate.
- Undefined:
  - No comparators are built; err is tied to 0.
  - Digits >9 are accumulated arithmetically (acc*10+digit).

Test Plan:
1. bcd=16'h1234, in_valid pulse in IDLE -> out_valid exactly 4 cycles after accept, bin=14'd1234 (0x04D2), err=0; out_ready=1 returns to IDLE, in_ready=1.
2. bcd=16'h9999 -> bin=9999 (0x270F), no overflow; then bcd=16'h0000 -> bin=0.
3. Backpressure: convert 16'h0042, hold out_ready=0 for 5 cycles -> out_valid=1, bin=42 stable throughout, in_ready=0, a second in_valid with 16'h0007 ignored. Release out_ready -> IDLE; resend 16'h0007 -> bin=7.
4. Reset mid-operation: accept 16'h5678, drop rst_n after 2 CONV cycles -> outputs immediately at reset values. After release: no out_valid appears; next input 16'h0100 gives bin=100.
5. Invalid digit bcd=16'h12A4:
   - With BCD_DIGIT_CHECK_EN: err=1, bin=1304 (0x0518).
   - Without it: err=0, bin=1304.
6. Back-to-back: in_valid held high with 16'h0001 then 16'h0002, out_ready=1 -> two results 1 and 2, accepts exactly DIGITS+2 cycles apart.

Source files
------------

// File: rtl/bcd_binary_seq.sv
// ---------------------------------------------------------------------------
// bcd_binary_seq
//
// Sequential BCD-to-binary converter. A packed DIGITS-digit BCD word is
// accepted over a valid/ready handshake and converted most-significant digit
// first by multiply-by-10 accumulate, one digit per clock. The binary result
// is offered on a second valid/ready handshake.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both 1. A producer holding valid keeps its data
// stable until the transfer. This block never drops out_valid without
// out_ready.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous, active-low reset
//   in_valid   in   bcd holds a word to convert
//   in_ready   out  block can accept a word (IDLE only)
//   bcd        in   packed BCD, digit DIGITS-1 in the MSBs
//   out_valid  out  bin/err hold a completed result (DONE only)
//   out_ready  in   consumer takes the result
//   bin        out  binary result, modulo 2^BIN_W
//   err        out  some input digit was >9 (only with BCD_DIGIT_CHECK_EN)
//   state_dbg  out  current FSM state (0=IDLE, 1=CONV, 2=DONE)
//
// Build option: define BCD_DIGIT_CHECK_EN to build the per-digit >9 check
// and the sticky error flag. Without it err is tied to 0 and digits >9 are
// simply accumulated as their numeric value.
// ---------------------------------------------------------------------------
module bcd_binary_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin,
  output logic                  err,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Counter only needs to index digits 0..DIGITS-1.
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e              state_q, state_d;
  logic [4*DIGITS-1:0] sr_q, sr_d;
  logic [BIN_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIN_W-1:0]    bin_q, bin_d;

  logic [3:0]          digit;
  logic [BIN_W-1:0]    acc_step;
  logic                last_digit;

  assign digit      = sr_q[4*DIGITS-1 -: 4];
  // acc*10 + digit without a multiplier; wraps modulo 2^BIN_W.
  assign acc_step   = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);
  assign last_digit = (cnt_q == CNT_W'(DIGITS - 1));

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)   state_d = S_CONV;
      S_CONV:  if (last_digit) state_d = S_DONE;
      S_DONE:  if (out_ready)  state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    state_dbg = state_q;
  end

  assign bin = bin_q;

  // ---------------- datapath ----------------
  always_comb begin
    sr_d  = sr_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    bin_d = bin_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sr_d  = bcd;
          acc_d = '0;
          cnt_d = '0;
        end
      end
      S_CONV: begin
        acc_d = acc_step;
        sr_d  = sr_q << 4;
        cnt_d = last_digit ? '0 : cnt_q + CNT_W'(1);
        if (last_digit) bin_d = acc_step;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      bin_q <= '0;
    end else begin
      sr_q  <= sr_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      bin_q <= bin_d;
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  // Sticky flag collects any digit >9 seen during CONV; err is captured
  // together with bin so both stay stable through DONE.
  logic flag_q, flag_d;
  logic err_q, err_d;
  logic digit_bad;

  assign digit_bad = (digit > 4'd9);

  always_comb begin
    flag_d = flag_q;
    err_d  = err_q;
    case (state_q)
      S_IDLE: if (in_valid) flag_d = 1'b0;
      S_CONV: begin
        flag_d = flag_q | digit_bad;
        if (last_digit) err_d = flag_q | digit_bad;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_binary_seq.sv
module tb_bcd_binary_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int TMO    = 50;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [4*DIGITS-1:0] bcd = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [BIN_W-1:0]    bin;
  logic                err;
  logic [1:0]          state_dbg;

  bcd_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .bcd(bcd),
    .out_valid(out_valid), .out_ready(out_ready),
    .bin(bin), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_asserts = 0;
  int n_fail    = 0;
  logic [BIN_W:0] exp_q[$];   // {err, bin}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal place-value sum of the digits, modulo 2^BIN_W.
  function automatic logic [BIN_W:0] ref_conv(input logic [4*DIGITS-1:0] w);
    longint unsigned v = 0;
    logic e = 1'b0;
    int unsigned d;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = (w >> (4 * i)) & 4'hF;
      v = (v * 10 + d) % (64'd1 << BIN_W);
`ifdef BCD_DIGIT_CHECK_EN
      if (d > 9) e = 1'b1;
`endif
    end
    return {e, v[BIN_W-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word and hold it until accepted; returns after the accept edge.
  task automatic send(input logic [4*DIGITS-1:0] w, input string tag);
    int t = 0;
    while (!in_ready && t < TMO) begin tick(); t++; end
    check({tag, "_ready_tmo"}, (t < TMO), 1);
    in_valid = 1'b1;
    bcd      = w;
    exp_q.push_back(ref_conv(w));
    tick();
    in_valid = 1'b0;
  endtask

  // Wait for out_valid, checking latency from accept, then compare result.
  task automatic wait_result(input string tag, input int hold);
    int lat = 0;
    logic [BIN_W:0] e;
    while (!out_valid && lat < TMO) begin tick(); lat++; end
    check({tag, "_latency"}, lat, DIGITS);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, out_valid, 1);
    end
    check({tag, "_bin"}, bin, e[BIN_W-1:0]);
    check({tag, "_err"}, err, e[BIN_W]);
    check({tag, "_in_ready_done"}, in_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_back_idle"}, {in_ready, out_valid}, 2'b10);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    int acc_n, res_n;
    int unsigned acc_t[2];
    logic [BIN_W-1:0] res_v[2];
    logic p_ir, p_iv, p_ov, p_or;
    logic [BIN_W-1:0] p_bin;
    logic [4*DIGITS-1:0] w;

    // reset
    repeat (3) tick();
    check("reset_outputs", {in_ready, out_valid, bin, err}, {1'b1, 1'b0, {BIN_W{1'b0}}, 1'b0});
    rst_n = 1'b1;
    tick();

    // 1: basic conversion
    send(16'h1234, "t1");
    wait_result("t1", 0);

    // 2: largest value, then zero
    send(16'h9999, "t2a");
    wait_result("t2a", 0);
    send(16'h0000, "t2b");
    wait_result("t2b", 0);

    // 3: backpressure, second word ignored while busy
    send(16'h0042, "t3");
    seen = 0;
    while (!out_valid && seen < TMO) begin tick(); seen++; end
    check("t3_latency", seen, DIGITS);
    in_valid = 1'b1;
    bcd      = 16'h0007;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_bp_state", {out_valid, in_ready, bin}, {1'b1, 1'b0, BIN_W'(42)});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    check("t3_release_idle", {in_ready, out_valid}, 2'b10);
    send(16'h0007, "t3b");
    wait_result("t3b", 0);

    // 4: reset mid-conversion
    send(16'h5678, "t4");
    void'(exp_q.pop_front());
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("t4_async_reset", {in_ready, out_valid, bin, err}, {1'b1, 1'b0, {BIN_W{1'b0}}, 1'b0});
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (out_valid) seen++; end
    check("t4_no_stale_valid", seen, 0);
    send(16'h0100, "t4b");
    wait_result("t4b", 0);

    // 5: invalid digit
    send(16'h12A4, "t5");
    wait_result("t5", 0);

    // 6: back-to-back with in_valid and out_ready held high
    acc_n = 0; res_n = 0;
    in_valid  = 1'b1;
    bcd       = 16'h0001;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && (acc_n < 2 || res_n < 2); i++) begin
      p_ir = in_ready; p_iv = in_valid; p_ov = out_valid; p_or = out_ready; p_bin = bin;
      tick();
      if (p_ir && p_iv && acc_n < 2) begin
        acc_t[acc_n] = cyc;
        acc_n++;
        if (acc_n == 1) bcd = 16'h0002;
        else in_valid = 1'b0;
      end
      if (p_ov && p_or && res_n < 2) begin
        res_v[res_n] = p_bin;
        res_n++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("t6_accept_count", acc_n, 2);
    check("t6_result_count", res_n, 2);
    if (acc_n == 2) check("t6_interval", acc_t[1] - acc_t[0], DIGITS + 2);
    if (res_n == 2) begin
      check("t6_res0", res_v[0], 1);
      check("t6_res1", res_v[1], 2);
    end
    tick();

    // random words, occasional non-decimal digits, random backpressure
    for (int n = 0; n < 16; n++) begin
      for (int d = 0; d < DIGITS; d++)
        w[4*d +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(0, 9));
      send(w, "rnd");
      wait_result("rnd", $urandom_range(0, 3));
    end

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
